hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline stall/flush sequencer for the 5-stage rv32i pipeline.
- Pairs with the EX-stage forwarding mux logic. That logic resolves every RAW hazard except load-use; this block covers load-use and everything else.
- Duties: load-use interlock, freezing on instruction/data memory waits, IF/ID flush on taken branch/jump redirect.
- Includes a one-entry fetch-hold buffer, so an instruction returned while the pipeline is frozen is not lost.
- Provides a saturating stall counter for performance monitoring.

Parameters:
CNT_WIDTH, 32, width of stall_count

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ID_rs1  in  5  rv32i_reg, rs1 of instruction in ID
ID_rs2  in  5  rv32i_reg, rs2 of instruction in ID
ID_uses_rs1  in  1  ID instruction reads rs1
ID_uses_rs2  in  1  ID instruction reads rs2
EX_rd  in  5  rv32i_reg, rd of instruction in EX
EX_is_load  in  1  EX instruction is a load
EX_redirect  in  1  EX resolved a taken branch/jal/jalr
imem_read_req  in  1  IF wants a fetch this cycle
imem_resp  in  1  instruction memory response
imem_rdata  in  32  instruction memory data
dmem_req  in  1  MEM stage has an outstanding load/store
dmem_resp  in  1  data memory response
imem_read  out  1  gated fetch request to memory
if_inst  out  32  instruction presented to IF/ID
if_inst_valid  out  1  if_inst valid this cycle
pc_stall  out  1  hold PC
IF_ID_stall  out  1  hold IF/ID
ID_EX_stall  out  1  hold ID/EX
EX_MEM_stall  out  1  hold EX/MEM
MEM_WB_stall  out  1  hold MEM/WB
IF_ID_flush  out  1  load NOP into IF/ID
ID_EX_bubble  out  1  load NOP into ID/EX
MEM_WB_bubble  out  1  load NOP into MEM/WB
stall_count  out  CNT_WIDTH  saturating count of pc_stall cycles

Behaviour:
Internal signals:
- dwait = dmem_req & ~dmem_resp.
- iwait = imem_read & ~imem_resp.
- freeze = dwait | iwait | (state==HOLD & dwait).
- loaduse = EX_is_load & EX_rd!=0 & ((ID_uses_rs1 & ID_rs1==EX_rd) | (ID_uses_rs2 & ID_rs2==EX_rd)).

Output priority (combinational from inputs and state): rst > freeze > EX_redirect > loaduse.
- Freeze:
  - pc/IF_ID/ID_EX/EX_MEM stalls all = 1.
  - If dwait: MEM_WB_stall=0 and MEM_WB_bubble=1, so WB retires nothing.
  - If iwait only: MEM_WB_stall=1.
  - No flush.
- Redirect (no freeze): IF_ID_flush=1, ID_EX_bubble=1, all stalls 0. PC loads the target in the same cycle.
- Load-use (no freeze, no redirect): pc_stall=1, IF_ID_stall=1, ID_EX_bubble=1, others 0. Exactly one bubble per load; next cycle the load is in MEM and forwarding resolves the hazard.
- Otherwise: all stall/flush/bubble outputs 0.

Fetch-hold FSM, states RUN, HOLD; reset to RUN:
- RUN:
  - imem_read = imem_read_req. if_inst = imem_rdata. if_inst_valid = imem_resp.
  - If imem_resp & dwait: latch imem_rdata into hold_q and go to HOLD.
- HOLD:
  - imem_read = 0. if_inst = hold_q. if_inst_valid = 1. pc_stall stays 1 while dwait.
  - On the first cycle with ~dwait: IF/ID consumes hold_q (or discards it if EX_redirect); go to RUN.
- Reset in HOLD discards hold_q.

Counter:
- stall_count increments by 1 on each cycle with pc_stall=1.
- Saturates at all-ones; no wrap.
- Reset value 0.

Reset values:
- All 1-bit outputs 0, except imem_read, which follows imem_read_req combinationally.
- if_inst 0 during rst. stall_count 0. state RUN. hold_q 0.

Boundary cases:
- EX_rd=0 never interlocks.
- Load-use coincident with redirect: redirect wins, no PC stall.
- dmem_resp in the same cycle as dmem_req: no freeze.
- Redirect while frozen: held off until freeze drops; EX is stalled, so EX_redirect stays asserted.

Test Plan:
- lw x5 in EX, add using rs1=x5 in ID, ID_uses_rs1=1 -> one cycle of pc_stall=1, IF_ID_stall=1, ID_EX_bubble=1; stall_count 0→1.
- Same as above with EX_rd=0 -> no stall; all outputs 0.
- dmem_req=1, dmem_resp=0 for 3 cycles, then resp -> 3 cycles of pc/IF_ID/ID_EX/EX_MEM stall=1, MEM_WB_bubble=1; stall_count=3.
- imem_resp=1 with imem_rdata=0x00500093 during dwait ->
  - state=HOLD, imem_read=0 while imem_read_req=1.
  - After dmem_resp: if_inst=0x00500093 and if_inst_valid=1 for one cycle, then RUN.
- EX_redirect=1 together with loaduse=1 -> IF_ID_flush=1, ID_EX_bubble=1, pc_stall=0.
- Force stall_count to all-ones (CNT_WIDTH=4: 15), then pc_stall for 2 more cycles -> stays 15. Assert rst mid-HOLD -> RUN, counter 0, outputs 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - rv32i pipeline stall/flush sequencer with fetch-hold buffer and stall counter
module hazard_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           ID_rs1,
    input  logic [4:0]           ID_rs2,
    input  logic                 ID_uses_rs1,
    input  logic                 ID_uses_rs2,
    input  logic [4:0]           EX_rd,
    input  logic                 EX_is_load,
    input  logic                 EX_redirect,
    input  logic                 imem_read_req,
    input  logic                 imem_resp,
    input  logic [31:0]          imem_rdata,
    input  logic                 dmem_req,
    input  logic                 dmem_resp,
    output logic                 imem_read,
    output logic [31:0]          if_inst,
    output logic                 if_inst_valid,
    output logic                 pc_stall,
    output logic                 IF_ID_stall,
    output logic                 ID_EX_stall,
    output logic                 EX_MEM_stall,
    output logic                 MEM_WB_stall,
    output logic                 IF_ID_flush,
    output logic                 ID_EX_bubble,
    output logic                 MEM_WB_bubble,
    output logic [CNT_WIDTH-1:0] stall_count
);
    typedef enum logic {RUN, HOLD} state_t;

    state_t      state;
    logic [31:0] hold_q;
    logic        dwait;
    logic        iwait;
    logic        freeze;
    logic        loaduse;

    assign dwait   = dmem_req & ~dmem_resp;
    assign iwait   = imem_read & ~imem_resp;
    assign freeze  = dwait | iwait | ((state == HOLD) & dwait);
    assign loaduse = EX_is_load & (EX_rd != 5'd0) &
                     ((ID_uses_rs1 & (ID_rs1 == EX_rd)) | (ID_uses_rs2 & (ID_rs2 == EX_rd)));

    // While holding a fetched word the memory must not be asked for another.
    assign imem_read = (rst || state == RUN) ? imem_read_req : 1'b0;

    always_comb begin
        if_inst       = 32'd0;
        if_inst_valid = 1'b0;
        pc_stall      = 1'b0;
        IF_ID_stall   = 1'b0;
        ID_EX_stall   = 1'b0;
        EX_MEM_stall  = 1'b0;
        MEM_WB_stall  = 1'b0;
        IF_ID_flush   = 1'b0;
        ID_EX_bubble  = 1'b0;
        MEM_WB_bubble = 1'b0;
        if (!rst) begin
            if (state == HOLD) begin
                if_inst       = hold_q;
                if_inst_valid = 1'b1;
            end else begin
                if_inst       = imem_rdata;
                if_inst_valid = imem_resp;
            end
            if (freeze) begin
                pc_stall      = 1'b1;
                IF_ID_stall   = 1'b1;
                ID_EX_stall   = 1'b1;
                EX_MEM_stall  = 1'b1;
                // A pending load must not let WB retire a stale value.
                MEM_WB_stall  = ~dwait;
                MEM_WB_bubble = dwait;
            end else if (EX_redirect) begin
                IF_ID_flush   = 1'b1;
                ID_EX_bubble  = 1'b1;
            end else if (loaduse) begin
                pc_stall      = 1'b1;
                IF_ID_stall   = 1'b1;
                ID_EX_bubble  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            hold_q      <= 32'd0;
            stall_count <= '0;
        end else begin
            if (pc_stall && stall_count != {CNT_WIDTH{1'b1}})
                stall_count <= stall_count + CNT_WIDTH'(1);
            case (state)
                RUN: begin
                    if (imem_resp && dwait) begin
                        hold_q <= imem_rdata;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (!dwait)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - table-driven scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
    localparam int CW = 4;

    localparam logic [9:0] RD  = 10'h200;
    localparam logic [9:0] VL  = 10'h100;
    localparam logic [9:0] PC  = 10'h080;
    localparam logic [9:0] IFD = 10'h040;
    localparam logic [9:0] IDX = 10'h020;
    localparam logic [9:0] EXM = 10'h010;
    localparam logic [9:0] MWS = 10'h008;
    localparam logic [9:0] FL  = 10'h004;
    localparam logic [9:0] IDB = 10'h002;
    localparam logic [9:0] MWB = 10'h001;
    localparam logic [9:0] DW  = PC | IFD | IDX | EXM | MWB;
    localparam logic [9:0] IW  = PC | IFD | IDX | EXM | MWS;
    localparam logic [9:0] LU  = PC | IFD | IDB;
    localparam logic [9:0] RDR = FL | IDB;

    typedef struct {
        logic        rst;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2, ld, redir, ireq, iresp, dreq, dresp;
        logic [31:0] idata;
        logic [9:0]  eflags;
        logic [31:0] einst;
    } vec_t;

    typedef struct {
        int          idx;
        logic [9:0]  flags;
        logic [31:0] inst;
        logic [CW-1:0] cnt;
        logic        cnt_known;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] ID_rs1, ID_rs2, EX_rd;
    logic ID_uses_rs1, ID_uses_rs2, EX_is_load, EX_redirect;
    logic imem_read_req, imem_resp, dmem_req, dmem_resp;
    logic [31:0] imem_rdata;
    logic imem_read, if_inst_valid, pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall;
    logic MEM_WB_stall, IF_ID_flush, ID_EX_bubble, MEM_WB_bubble;
    logic [31:0] if_inst;
    logic [CW-1:0] stall_count;

    vec_t tbl[64];
    int   n_tbl = 0;
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .EX_rd(EX_rd), .EX_is_load(EX_is_load), .EX_redirect(EX_redirect),
        .imem_read_req(imem_read_req), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .imem_read(imem_read), .if_inst(if_inst), .if_inst_valid(if_inst_valid),
        .pc_stall(pc_stall), .IF_ID_stall(IF_ID_stall), .ID_EX_stall(ID_EX_stall),
        .EX_MEM_stall(EX_MEM_stall), .MEM_WB_stall(MEM_WB_stall), .IF_ID_flush(IF_ID_flush),
        .ID_EX_bubble(ID_EX_bubble), .MEM_WB_bubble(MEM_WB_bubble), .stall_count(stall_count)
    );

    task automatic add(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                       input logic a1, input logic a2, input logic [4:0] d, input logic l,
                       input logic rdr, input logic irq, input logic irs, input logic [31:0] idat,
                       input logic drq, input logic drs, input logic [9:0] ef, input logic [31:0] ei);
        vec_t v;
        v.rst = r; v.rs1 = s1; v.rs2 = s2; v.u1 = a1; v.u2 = a2; v.rd = d; v.ld = l;
        v.redir = rdr; v.ireq = irq; v.iresp = irs; v.idata = idat; v.dreq = drq; v.dresp = drs;
        v.eflags = ef; v.einst = ei;
        tbl[n_tbl] = v;
        n_tbl++;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        if (got !== want) begin
            n_err++;
            $display("FAIL %s vec %0d: got %h, want %h", name, idx, got, want);
        end
    endtask

    initial begin
        logic [CW-1:0] exp_cnt;
        logic          cnt_known;
        exp_t          e;
        logic [9:0]    got_flags;

        // reset, with and without a fetch request and a pending data wait
        add(1, 0,0,0,0, 0,0,0, 0,0,32'h0, 0,0, 10'h0, 32'h0);
        add(1, 0,0,0,0, 0,0,0, 1,1,32'h55, 1,0, RD, 32'h0);
        // plain fetch
        add(0, 0,0,0,0, 0,0,0, 1,1,32'h13, 0,0, RD|VL, 32'h13);
        // load-use on rs1, then x0 destination, rs1 unused, rs2 match, non-load
        add(0, 5,0,1,0, 5,1,0, 1,1,32'h2081b3, 0,0, RD|VL|LU, 32'h2081b3);
        add(0, 0,0,1,0, 0,1,0, 1,1,32'h33, 0,0, RD|VL, 32'h33);
        add(0, 7,3,0,1, 7,1,0, 1,1,32'h33, 0,0, RD|VL, 32'h33);
        add(0, 3,7,1,1, 7,1,0, 1,1,32'h33, 0,0, RD|VL|LU, 32'h33);
        add(0, 7,7,1,1, 7,0,0, 1,1,32'h33, 0,0, RD|VL, 32'h33);
        // redirect beats load-use; redirect alone
        add(0, 5,0,1,0, 5,1,1, 1,1,32'h33, 0,0, RD|VL|RDR, 32'h33);
        add(0, 0,0,0,0, 0,0,1, 0,0,32'h0, 0,0, RDR, 32'h0);
        // three cycles of data wait, then same-cycle response
        for (int i = 0; i < 3; i++)
            add(0, 0,0,0,0, 0,0,0, 0,0,32'h0, 1,0, DW, 32'h0);
        add(0, 0,0,0,0, 0,0,0, 0,0,32'h0, 1,1, 10'h0, 32'h0);
        // instruction wait
        add(0, 0,0,0,0, 0,0,0, 1,0,32'h0, 0,0, RD|IW, 32'h0);
        // fetch lands during data wait -> HOLD; redirect held off; release; back to RUN
        add(0, 0,0,0,0, 0,0,0, 1,1,32'h00500093, 1,0, RD|VL|DW, 32'h00500093);
        add(0, 0,0,0,0, 0,0,1, 1,0,32'hdeadbeef, 1,0, VL|DW, 32'h00500093);
        add(0, 0,0,0,0, 0,0,0, 1,0,32'hdeadbeef, 1,1, VL, 32'h00500093);
        add(0, 0,0,0,0, 0,0,0, 1,1,32'h13, 0,0, RD|VL, 32'h13);
        // drive the counter into saturation and past it
        for (int i = 0; i < 9; i++)
            add(0, 0,0,0,0, 0,0,0, 0,0,32'h0, 1,0, DW, 32'h0);
        // enter HOLD, reset there, confirm RUN with a cleared counter
        add(0, 0,0,0,0, 0,0,0, 1,1,32'h00a00113, 1,0, RD|VL|DW, 32'h00a00113);
        add(1, 0,0,0,0, 0,0,0, 1,0,32'h0, 1,0, RD, 32'h0);
        add(0, 0,0,0,0, 0,0,0, 1,1,32'h13, 0,0, RD|VL, 32'h13);
        add(0, 0,0,0,0, 0,0,0, 0,0,32'h0, 0,0, 10'h0, 32'h0);

        exp_cnt   = '0;
        cnt_known = 1'b0;
        for (int i = 0; i < n_tbl; i++) begin
            @(posedge clk);
            #1;
            rst = tbl[i].rst; ID_rs1 = tbl[i].rs1; ID_rs2 = tbl[i].rs2;
            ID_uses_rs1 = tbl[i].u1; ID_uses_rs2 = tbl[i].u2; EX_rd = tbl[i].rd;
            EX_is_load = tbl[i].ld; EX_redirect = tbl[i].redir;
            imem_read_req = tbl[i].ireq; imem_resp = tbl[i].iresp; imem_rdata = tbl[i].idata;
            dmem_req = tbl[i].dreq; dmem_resp = tbl[i].dresp;
            e.idx = i; e.flags = tbl[i].eflags; e.inst = tbl[i].einst;
            e.cnt = exp_cnt; e.cnt_known = cnt_known;
            sb.push_back(e);

            @(negedge clk);
            e = sb.pop_front();
            got_flags = {imem_read, if_inst_valid, pc_stall, IF_ID_stall, ID_EX_stall,
                         EX_MEM_stall, MEM_WB_stall, IF_ID_flush, ID_EX_bubble, MEM_WB_bubble};
            n_vec++;
            check("flags", e.idx, {22'd0, got_flags}, {22'd0, e.flags});
            check("if_inst", e.idx, if_inst, e.inst);
            if (e.cnt_known)
                check("stall_count", e.idx, {{(32-CW){1'b0}}, stall_count}, {{(32-CW){1'b0}}, e.cnt});

            if (tbl[i].rst) begin
                exp_cnt   = '0;
                cnt_known = 1'b1;
            end else if (tbl[i].eflags[7] && exp_cnt != {CW{1'b1}}) begin
                exp_cnt = exp_cnt + 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
